// File: rtl/vector_logic_station.sv
// Purpose : multi-lane bitwise/shift logic unit; issue -> S1 stage -> in-order result queue -> commit handshake.
// Latency : result at the queue head two cycles after the accepting edge's cycle (no bypass); 1 op/cycle sustained.
// Backpressure: oIssueReady only when a queue slot is reserved for the op (S1 + queue occupancy); oBusy = ~oIssueReady.
// Ports   : Clock/Reset (async, active high); issue side iIssueValid/oIssueReady, iOp, iRsId, iDst, iWE, iA, iB;
//           commit side oCommitRequest/iCommitGranted with head fields oRsId, oDst, oWE, oResult, oZero.
//           Lane 0 occupies the MSBs of iA/iB/oResult, and likewise the MSB of oZero.
module vector_logic_station #(
    parameter int WIDTH = 32,
    parameter int LANES = 3,
    parameter int DEPTH = 2,
    parameter int DST_W = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iIssueValid,
    output logic                   oIssueReady,
    input  logic [2:0]             iOp,
    input  logic [3:0]             iRsId,
    input  logic [DST_W-1:0]       iDst,
    input  logic [LANES-1:0]       iWE,
    input  logic [LANES*WIDTH-1:0] iA,
    input  logic [LANES*WIDTH-1:0] iB,
    output logic                   oCommitRequest,
    input  logic                   iCommitGranted,
    output logic [3:0]             oRsId,
    output logic [DST_W-1:0]       oDst,
    output logic [LANES-1:0]       oWE,
    output logic [LANES*WIDTH-1:0] oResult,
    output logic [LANES-1:0]       oZero,
    output logic                   oBusy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SH_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOTA = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    // ------------------------------------------------------------------
    // Control state (async reset) and S1 payload (load-enabled, no reset)
    // ------------------------------------------------------------------
    logic                   s1_vld_q, s1_vld_d;
    logic [2:0]             s1_op_q;
    logic [3:0]             s1_rsid_q;
    logic [DST_W-1:0]       s1_dst_q;
    logic [LANES-1:0]       s1_we_q;
    logic [LANES*WIDTH-1:0] s1_a_q;
    logic [LANES*WIDTH-1:0] s1_b_q;

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    // Result queue storage; only entries between rd and wr are ever observed.
    logic [LANES*WIDTH-1:0] res_mem  [DEPTH];
    logic [LANES-1:0]       zero_mem [DEPTH];
    logic [LANES-1:0]       we_mem   [DEPTH];
    logic [3:0]             rsid_mem [DEPTH];
    logic [DST_W-1:0]       dst_mem  [DEPTH];

    logic                   accept;
    logic                   push;
    logic                   pop;
    logic [CNT_W:0]         occupancy;
    logic [CNT_W:0]         limit;

    logic [LANES*WIDTH-1:0] res_d;
    logic [LANES-1:0]       zero_d;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign oCommitRequest = (count_q != '0);
    assign pop            = oCommitRequest & iCommitGranted;
    assign push           = s1_vld_q;
    assign accept         = iIssueValid & oIssueReady;

    // A slot is reserved for every op in S1. A head being popped this
    // cycle frees its slot at the same edge, so it is credited here; that
    // credit is what lets DEPTH=2 sustain one issue per cycle.
    always_comb begin
        occupancy   = {1'b0, count_q} + (CNT_W+1)'(s1_vld_q);
        limit       = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop);
        oIssueReady = ~Reset & (occupancy < limit);
    end

    assign oBusy = ~oIssueReady;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        // S1 always drains into the queue the edge after it fills, so it
        // is valid next cycle only if a new issue lands on this edge.
        s1_vld_d = accept;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_vld_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (accept) begin
            s1_op_q   <= iOp;
            s1_rsid_q <= iRsId;
            s1_dst_q  <= iDst;
            s1_we_q   <= iWE;
            s1_a_q    <= iA;
            s1_b_q    <= iB;
        end
    end

    // ------------------------------------------------------------------
    // Lane datapath: every lane is computed regardless of its write enable.
    // ------------------------------------------------------------------
    always_comb begin
        logic [WIDTH-1:0] lane_a;
        logic [WIDTH-1:0] lane_b;
        logic [WIDTH-1:0] lane_r;
        logic [SH_W-1:0]  shamt;
        res_d  = '0;
        zero_d = '0;
        lane_a = '0;
        lane_b = '0;
        lane_r = '0;
        shamt  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_a = s1_a_q[(LANES-1-i)*WIDTH +: WIDTH];
            lane_b = s1_b_q[(LANES-1-i)*WIDTH +: WIDTH];
            // Shift distance uses only the low log2(WIDTH) bits of B.
            shamt  = lane_b[SH_W-1:0];
            case (s1_op_q)
                OP_AND:  lane_r = lane_a & lane_b;
                OP_OR:   lane_r = lane_a | lane_b;
                OP_XOR:  lane_r = lane_a ^ lane_b;
                OP_NOTA: lane_r = ~lane_a;
                OP_NAND: lane_r = ~(lane_a & lane_b);
                OP_NOR:  lane_r = ~(lane_a | lane_b);
                OP_SHL:  lane_r = lane_a << shamt;
                OP_SHR:  lane_r = lane_a >> shamt;
                default: lane_r = '0;
            endcase
            res_d[(LANES-1-i)*WIDTH +: WIDTH] = lane_r;
            zero_d[LANES-1-i]                 = (lane_r == '0);
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            res_mem[wr_ptr_q]  <= res_d;
            zero_mem[wr_ptr_q] <= zero_d;
            we_mem[wr_ptr_q]   <= s1_we_q;
            rsid_mem[wr_ptr_q] <= s1_rsid_q;
            dst_mem[wr_ptr_q]  <= s1_dst_q;
        end
    end

    // ------------------------------------------------------------------
    // Head outputs: zero whenever the queue is empty (including reset), so
    // stale storage never leaks out. A push never targets the head slot
    // while entries are queued, so the head holds while ungranted.
    // ------------------------------------------------------------------
    always_comb begin
        oResult = '0;
        oZero   = '0;
        oWE     = '0;
        oRsId   = '0;
        oDst    = '0;
        if (oCommitRequest) begin
            oResult = res_mem[rd_ptr_q];
            oZero   = zero_mem[rd_ptr_q];
            oWE     = we_mem[rd_ptr_q];
            oRsId   = rsid_mem[rd_ptr_q];
            oDst    = dst_mem[rd_ptr_q];
        end
    end

endmodule
